// File: rtl/seq_divider_8bit.sv
// Multi-cycle unsigned restoring divider. One quotient bit per clock, started and
// finished with a start/busy/done handshake. Operands are captured when start is accepted.
//
// state | meaning
// IDLE  | waiting for start; results from the previous division are held
// RUN   | shift-and-subtract, one quotient bit per clock, WIDTH steps in total
// DONE  | done pulse for one cycle, then back to IDLE
module seq_divider_8bit #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] p_rem;
   logic [WIDTH-1:0] q_acc;
   logic [WIDTH-1:0] divisor_q;

   logic [WIDTH:0]   p_shift;
   logic [WIDTH:0]   trial;
   logic [WIDTH-1:0] p_next;
   logic [WIDTH-1:0] q_next;

   // The partial remainder stays below the divisor, so its top bit is always zero
   // and only the low WIDTH bits need to be stored.
   always_comb begin
      p_shift = {p_rem, q_acc[WIDTH-1]};
      trial   = p_shift - {1'b0, divisor_q};
      p_next  = trial[WIDTH] ? p_shift[WIDTH-1:0] : trial[WIDTH-1:0];
      q_next  = {q_acc[WIDTH-2:0], ~trial[WIDTH]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         count       <= '0;
         p_rem       <= '0;
         q_acc       <= '0;
         divisor_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  divisor_q <= divisor;
                  if (divisor != '0) begin
                     state       <= RUN;
                     busy        <= 1'b1;
                     count       <= '0;
                     p_rem       <= '0;
                     q_acc       <= dividend;
                     div_by_zero <= 1'b0;
                  end else begin
                     state       <= DONE;
                     done        <= 1'b1;
                     quotient    <= '1;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                  end
               end
            end
            RUN: begin
               p_rem <= p_next;
               q_acc <= q_next;
               count <= count + 1'b1;
               if (count == CW'(WIDTH - 1)) begin
                  state     <= DONE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  quotient  <= q_next;
                  remainder <= p_next;
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider_8bit.sv
// Self-checking bench for seq_divider_8bit: directed corner cases plus random
// operands compared against plain integer division.
module tb_seq_divider_8bit;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] dividend;
   logic [7:0] divisor;
   logic       busy;
   logic       done;
   logic [7:0] quotient;
   logic [7:0] remainder;
   logic       div_by_zero;

   int checks = 0;
   int errors = 0;

   seq_divider_8bit #(.WIDTH(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Runs one division starting in the current cycle (caller is #1 after an edge).
   // poke_at > 0 pulses a second start with different operands on that busy cycle.
   task automatic do_div(input logic [7:0] a, input logic [7:0] b, input int poke_at);
      int         edges;
      int         busy_cyc;
      logic       seen;
      logic [7:0] exp_q;
      logic [7:0] exp_r;
      exp_q = (b == 0) ? 8'hFF : 8'(a / b);
      exp_r = (b == 0) ? a : 8'(a % b);
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      @(posedge clk);
      #1;
      start    = 1'b0;
      dividend = 8'($urandom);
      divisor  = 8'($urandom);
      edges    = 1;
      busy_cyc = 0;
      seen     = 1'b0;
      while (!seen && edges <= 20) begin
         check_eq("busy_done_overlap", 32'(busy & done), 0);
         if (busy) busy_cyc++;
         start = (poke_at > 0) && busy && (busy_cyc == poke_at);
         if (start) begin
            dividend = 8'd50;
            divisor  = 8'd5;
         end
         if (done) begin
            seen = 1'b1;
         end else begin
            @(posedge clk);
            #1;
            edges++;
         end
      end
      start = 1'b0;
      check_eq("done_seen", 32'(seen), 1);
      if (seen) begin
         check_eq("latency", edges, (b == 0) ? 1 : 9);
         check_eq("busy_cycles", busy_cyc, (b == 0) ? 0 : 8);
         check_eq("quotient", 32'(quotient), 32'(exp_q));
         check_eq("remainder", 32'(remainder), 32'(exp_r));
         check_eq("div_by_zero", 32'(div_by_zero), (b == 0) ? 1 : 0);
      end
      @(posedge clk);
      #1;
      check_eq("done_single_pulse", 32'(done), 0);
      check_eq("idle_after_done", 32'(busy), 0);
      check_eq("result_hold_q", 32'(quotient), 32'(exp_q));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   bc;
      logic seen_done;
      logic [7:0] ra;
      logic [7:0] rb;

      rst      = 1'b1;
      start    = 1'b0;
      dividend = 8'd0;
      divisor  = 8'd0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_busy", 32'(busy), 0);
      check_eq("rst_done", 32'(done), 0);
      check_eq("rst_quotient", 32'(quotient), 0);
      check_eq("rst_remainder", 32'(remainder), 0);
      check_eq("rst_dbz", 32'(div_by_zero), 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      do_div(8'd100, 8'd7, 0);
      do_div(8'd255, 8'd1, 0);
      do_div(8'd5, 8'd9, 0);
      do_div(8'd255, 8'd255, 0);
      do_div(8'd0, 8'd3, 0);
      do_div(8'd42, 8'd0, 0);
      do_div(8'd10, 8'd3, 0);
      do_div(8'd200, 8'd9, 3);

      // Reset on the 4th busy cycle aborts the division with no done pulse.
      start    = 1'b1;
      dividend = 8'd100;
      divisor  = 8'd7;
      @(posedge clk);
      #1;
      start = 1'b0;
      bc    = 0;
      for (int i = 0; i < 20 && bc < 4; i++) begin
         if (busy) bc++;
         if (bc < 4) begin
            @(posedge clk);
            #1;
         end
      end
      check_eq("reached_4th_busy", bc, 4);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_eq("abort_busy", 32'(busy), 0);
      check_eq("abort_done", 32'(done), 0);
      check_eq("abort_quotient", 32'(quotient), 0);
      check_eq("abort_remainder", 32'(remainder), 0);
      seen_done = 1'b0;
      for (int i = 0; i < 12; i++) begin
         seen_done = seen_done | done | busy;
         @(posedge clk);
         #1;
      end
      check_eq("no_activity_after_abort", 32'(seen_done), 0);
      do_div(8'd9, 8'd2, 0);

      // Random operands, back-to-back, with an occasional zero divisor.
      for (int n = 0; n < 40; n++) begin
         ra = 8'($urandom);
         rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
         do_div(ra, rb, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
